// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver. Each bit is decided by a 3-sample majority vote
// around mid-bit. Received characters land, with their error flags, in a
// first-word-fall-through FIFO. The block also reports overflow and line silence.
//
// Read handshake: rdValid is high whenever the FIFO holds an entry. rdData and
// rdFlags show that head entry combinationally. The head is popped on any clk
// edge where rdValid && rdReady. rdReady while rdValid is low has no effect.
module uart_rx_fifo #(
  parameter int DIV_WIDTH   = 24,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CHARS  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [1:0]                    dataBits,
  input  logic                          hasParity,
  input  logic [1:0]                    parityMode,
  input  logic                          extraStopBit,
  input  logic [DIV_WIDTH-1:0]          clockDivisor,
  output logic [8:0]                    rdData,
  output logic [2:0]                    rdFlags,
  output logic                          rdValid,
  input  logic                          rdReady,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          overflowClr,
  output logic                          silence,
  output logic                          rxActive,
  output logic [2:0]                    dbg_state
);

  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int SIL_W = $clog2(IDLE_CHARS * OVERSAMPLE * 12 + 1) + 1;
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_V2   = SW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP1     = 3'd5,
    S_STOP2     = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic                   v0_q, v0_d, v1_q, v1_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   par_bit_q, par_bit_d;
  logic [1:0]             dbits_q, dbits_d;
  logic                   has_par_q, has_par_d;
  logic [1:0]             pmode_q, pmode_d;
  logic                   two_stop_q, two_stop_d;
  logic [10:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [SIL_W-1:0]       sil_cnt_q, sil_cnt_d;
  logic                   silence_q, silence_d;

  logic                   rxs, tick, vote_now, vote, push, par_err, framing, brk;
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [10:0]            push_word;
  logic                   pop, full, wr_en, drop;
  logic [3:0]             char_bits;
  logic [SIL_W-1:0]       sil_limit;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign rxActive  = (state_q != S_WAIT_HIGH) && (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Receive path: synchroniser, sample-tick divider, majority vote, frame FSM.
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    div_lat_d  = div_lat_q;
    samp_d     = samp_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    dbits_d    = dbits_q;
    has_par_d  = has_par_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    push       = 1'b0;

    // Outside a frame the divider follows the live divisor; inside it uses the latched one.
    div_eff   = rxActive ? div_lat_q : clockDivisor;
    tick      = (div_cnt_q >= div_eff);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);

    if (tick) begin
      samp_d = (samp_q == SAMP_LAST) ? '0 : samp_q + SW'(1);
      if (samp_q == SAMP_V0) v0_d = rxs;
      if (samp_q == SAMP_V1) v1_d = rxs;
    end
    vote_now = tick && (samp_q == SAMP_V2);
    vote     = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);

    // Flags are built from the settled data/parity registers at the stop-bit vote.
    unique case (pmode_q)
      2'b00:   par_err = par_bit_q;
      2'b11:   par_err = !par_bit_q;
      2'b10:   par_err = ^{data_q, par_bit_q};
      default: par_err = !(^{data_q, par_bit_q});
    endcase
    par_err   = par_err & has_par_q;
    framing   = !vote;
    brk       = framing && (data_q == 8'd0) && !par_bit_q;
    push_word = {brk, framing, par_err, data_q};

    unique case (state_q)
      S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
      S_IDLE: begin
        if (!rxs) begin
          state_d    = S_START;
          div_cnt_d  = '0;
          samp_d     = '0;
          bit_cnt_d  = '0;
          data_d     = '0;
          par_bit_d  = 1'b0;
          div_lat_d  = clockDivisor;
          dbits_d    = dataBits;
          has_par_d  = hasParity;
          pmode_d    = parityMode;
          two_stop_d = extraStopBit;
        end
      end
      S_START: if (vote_now) state_d = vote ? S_IDLE : S_DATA;
      S_DATA: begin
        if (vote_now) begin
          data_d[bit_cnt_q] = vote;
          if (bit_cnt_q == ({1'b0, dbits_q} + 3'd4)) begin
            state_d = has_par_q ? S_PARITY : S_STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (vote_now) begin
          par_bit_d = vote;
          state_d   = S_STOP1;
        end
      end
      S_STOP1, S_STOP2: begin
        if (vote_now) begin
          if (!vote) begin
            push    = 1'b1;
            state_d = S_WAIT_HIGH;
          end else if (state_q == S_STOP1 && two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_WAIT_HIGH;
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO only succeeds if a pop frees a slot in the same cycle.
  always_comb begin
    rdValid    = (count_q != '0);
    full       = (count_q == LW'(FIFO_DEPTH));
    pop        = rdValid && rdReady;
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop) count_d = count_q + LW'(1);
    if (!wr_en && pop) count_d = count_q - LW'(1);
    overflow_d = drop ? 1'b1 : (overflowClr ? 1'b0 : overflow_q);
    rdData     = rdValid ? {1'b0, mem_q[rd_ptr_q][7:0]} : 9'd0;
    rdFlags    = rdValid ? mem_q[rd_ptr_q][10:8] : 3'd0;
    level      = count_q;
    overflow   = overflow_q;
  end

  // Silence detector: counts ticks of idle-high line against the live character length.
  always_comb begin
    char_bits = 4'd7 + {2'b00, dataBits} + {3'b000, hasParity} + {3'b000, extraStopBit};
    sil_limit = SIL_W'(IDLE_CHARS * OVERSAMPLE) * {{(SIL_W-4){1'b0}}, char_bits};
    sil_cnt_d = '0;
    silence_d = 1'b0;
    if (state_q == S_IDLE && rxs) begin
      sil_cnt_d = (tick && sil_cnt_q < sil_limit) ? sil_cnt_q + SIL_W'(1) : sil_cnt_q;
      silence_d = silence_q || (sil_cnt_q >= sil_limit);
    end
    silence = silence_q;
  end

  // State registers; reset discards any partial frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_WAIT_HIGH;
      sync_q     <= '1;
      div_cnt_q  <= '0;
      div_lat_q  <= '0;
      samp_q     <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      dbits_q    <= '0;
      has_par_q  <= 1'b0;
      pmode_q    <= '0;
      two_stop_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sil_cnt_q  <= '0;
      silence_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      div_cnt_q  <= div_cnt_d;
      div_lat_q  <= div_lat_d;
      samp_q     <= samp_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      dbits_q    <= dbits_d;
      has_par_q  <= has_par_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sil_cnt_q  <= sil_cnt_d;
      silence_q  <= silence_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1, 7E1/7O1/7M1 parity, glitch rejection,
// 5N2, overflow with a 4-entry FIFO, break, reset mid-frame and silence.
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 16;

  logic        clk = 1'b0;
  logic        rst, rx, hasParity, extraStopBit, rdReady, overflowClr;
  logic [1:0]  dataBits, parityMode;
  logic [23:0] clockDivisor;
  logic [8:0]  rdData;
  logic [2:0]  rdFlags, level, dbg_state;
  logic        rdValid, overflow, silence, rxActive;
  logic        mid_active;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .dataBits(dataBits), .hasParity(hasParity),
    .parityMode(parityMode), .extraStopBit(extraStopBit), .clockDivisor(clockDivisor),
    .rdData(rdData), .rdFlags(rdFlags), .rdValid(rdValid), .rdReady(rdReady),
    .level(level), .overflow(overflow), .overflowClr(overflowClr),
    .silence(silence), .rxActive(rxActive), .dbg_state(dbg_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Driver tasks: all driving and sampling happens at negedge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_val, input int nstop);
    send_bit(1'b0);
    mid_active = rxActive;
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (par_en) send_bit(par_val);
    for (int i = 0; i < nstop; i++) send_bit(1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic hp, input logic [1:0] pm, input logic xs);
    dataBits = db; hasParity = hp; parityMode = pm; extraStopBit = xs;
  endtask

  task automatic do_pop();
    rdReady = 1'b1;
    @(negedge clk);
    rdReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rdReady = 1'b0; overflowClr = 1'b0; clockDivisor = 24'd0;
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (rdValid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_fifo valid=%b level=%0d ovf=%b exp 0/0/0", rdValid, level, overflow);
    end
    checks++;
    if (silence !== 1'b0 || rxActive !== 1'b0 || rdData !== 9'd0 || rdFlags !== 3'd0) begin
      errors++; $display("FAIL reset_outs sil=%b act=%b data=%h flags=%b exp all 0", silence, rxActive, rdData, rdFlags);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state got=%0d exp=0 (WAIT_HIGH)", dbg_state);
    end
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic test_8n1();
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1);
    checks++;
    if (mid_active !== 1'b1) begin
      errors++; $display("FAIL active_mid_frame got=%b exp=1", mid_active);
    end
    checks++;
    if (rdValid !== 1'b1 || level !== 3'd1) begin
      errors++; $display("FAIL 8n1_level valid=%b level=%0d exp 1/1", rdValid, level);
    end
    checks++;
    if (rdData !== 9'h0A5 || rdFlags !== 3'b000) begin
      errors++; $display("FAIL 8n1_data data=%h flags=%b exp 0a5/000", rdData, rdFlags);
    end
    do_pop();
    checks++;
    if (rdValid !== 1'b0 || level !== 3'd0 || rdData !== 9'd0) begin
      errors++; $display("FAIL 8n1_pop valid=%b level=%0d data=%h exp 0/0/000", rdValid, level, rdData);
    end
  endtask

  task automatic test_parity();
    set_cfg(2'd2, 1'b1, 2'b10, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1);
    checks++;
    if (rdData !== 9'h041 || rdFlags !== 3'b001) begin
      errors++; $display("FAIL 7e1_bad data=%h flags=%b exp 041/001", rdData, rdFlags);
    end
    do_pop();
    send_frame(8'h41, 7, 1'b1, 1'b0, 1);
    checks++;
    if (rdData !== 9'h041 || rdFlags !== 3'b000) begin
      errors++; $display("FAIL 7e1_good data=%h flags=%b exp 041/000", rdData, rdFlags);
    end
    do_pop();
    set_cfg(2'd2, 1'b1, 2'b01, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1);
    checks++;
    if (rdFlags !== 3'b000) begin
      errors++; $display("FAIL 7o1_good flags=%b exp 000", rdFlags);
    end
    do_pop();
    set_cfg(2'd2, 1'b1, 2'b11, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1);
    checks++;
    if (rdFlags !== 3'b001) begin
      errors++; $display("FAIL 7m1_bad flags=%b exp 001", rdFlags);
    end
    do_pop();
  endtask

  task automatic test_glitch_5n2();
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++;
    if (level !== 3'd0 || rxActive !== 1'b0) begin
      errors++; $display("FAIL glitch level=%0d act=%b exp 0/0", level, rxActive);
    end
    set_cfg(2'd0, 1'b0, 2'b00, 1'b1);
    send_frame(8'h15, 5, 1'b0, 1'b0, 2);
    checks++;
    if (level !== 3'd1 || rdData !== 9'h015 || rdFlags !== 3'b000) begin
      errors++; $display("FAIL 5n2 level=%0d data=%h flags=%b exp 1/015/000", level, rdData, rdFlags);
    end
    do_pop();
  endtask

  task automatic test_overflow();
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_full level=%0d ovf=%b exp 4/0", level, overflow);
    end
    send_frame(8'h05, 8, 1'b0, 1'b0, 1);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || rdData !== 9'h001) begin
      errors++; $display("FAIL ovf_drop level=%0d ovf=%b head=%h exp 4/1/001", level, overflow, rdData);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rdData !== 9'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, rdData, 9'(i));
      end
      do_pop();
    end
    checks++;
    if (level !== 3'd0 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drained level=%0d ovf=%b exp 0/1", level, overflow);
    end
    overflowClr = 1'b1;
    @(negedge clk);
    overflowClr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
  endtask

  task automatic test_break();
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    checks++;
    if (level !== 3'd1 || rdData !== 9'd0 || rdFlags !== 3'b110) begin
      errors++; $display("FAIL break level=%0d data=%h flags=%b exp 1/000/110", level, rdData, rdFlags);
    end
    send_frame(8'h33, 8, 1'b0, 1'b0, 1);
    checks++;
    if (level !== 3'd2) begin
      errors++; $display("FAIL break_count level=%0d exp=2", level);
    end
    do_pop();
    checks++;
    if (rdData !== 9'h033 || rdFlags !== 3'b000) begin
      errors++; $display("FAIL after_break data=%h flags=%b exp 033/000", rdData, rdFlags);
    end
    do_pop();
  endtask

  task automatic test_reset_mid_and_silence();
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (level !== 3'd0 || rxActive !== 1'b0) begin
      errors++; $display("FAIL rst_mid level=%0d act=%b exp 0/0", level, rxActive);
    end
    repeat (2 * BIT_CLK) @(negedge clk);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1);
    checks++;
    if (level !== 3'd1 || rdData !== 9'h07E || rdFlags !== 3'b000) begin
      errors++; $display("FAIL rst_then_7e level=%0d data=%h flags=%b exp 1/07e/000", level, rdData, rdFlags);
    end
    repeat (25 * BIT_CLK) @(negedge clk);
    checks++;
    if (silence !== 1'b0) begin
      errors++; $display("FAIL silence_early got=%b exp=0", silence);
    end
    repeat (6 * BIT_CLK) @(negedge clk);
    checks++;
    if (silence !== 1'b1) begin
      errors++; $display("FAIL silence_set got=%b exp=1", silence);
    end
    rx = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (silence !== 1'b0 || rxActive !== 1'b1) begin
      errors++; $display("FAIL silence_clear sil=%b act=%b exp 0/1", silence, rxActive);
    end
    rx = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_glitch_5n2();
    test_overflow();
    test_break();
    test_reset_mid_and_silence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
